// File: rtl/note_sequencer_if.sv
// Handshake bundle between the board top level and the melody player:
// beat and start/stop controls in, tone and status out.
interface note_sequencer_if;
    logic       beat_in;
    logic       play;
    logic       stop;
    logic       speaker;
    logic [3:0] note_idx;
    logic       playing;
    logic       done;

    // Board top level: drives the controls, observes tone and status.
    modport master (
        output beat_in, play, stop,
        input  speaker, note_idx, playing, done
    );

    // Melody player: consumes the controls, produces tone and status.
    modport slave (
        input  beat_in, play, stop,
        output speaker, note_idx, playing, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Melody player: steps through a fixed 16-entry melody ROM, one note per
// rising edge of the divider's beat output, and drives a square-wave tone
// for each note on the speaker pin.
module note_sequencer #(
    parameter int MELODY_LEN = 16
) (
    input  logic              clock,
    input  logic              reset,
    note_sequencer_if.slave   bus
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PLAYING = 1'b1;
    localparam logic [3:0] LAST_IDX   = 4'(MELODY_LEN - 1);

    // Melody ROM: note code per index.
    function automatic logic [3:0] rom_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd0;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd7;
            4'd11:   code = 4'd6;
            4'd12:   code = 4'd5;
            4'd13:   code = 4'd4;
            4'd14:   code = 4'd3;
            default: code = 4'd2;
        endcase
        return code;
    endfunction

    // Tone half-period in 50 MHz cycles; zero marks a rest.
    function automatic logic [16:0] half_period(input logic [3:0] code);
        logic [16:0] half;
        case (code)
            4'd1:    half = 17'd95556;  // C4
            4'd2:    half = 17'd85131;  // D4
            4'd3:    half = 17'd75843;  // E4
            4'd4:    half = 17'd71586;  // F4
            4'd5:    half = 17'd63776;  // G4
            4'd6:    half = 17'd56818;  // A4
            4'd7:    half = 17'd50619;  // B4
            4'd8:    half = 17'd47778;  // C5
            default: half = 17'd0;
        endcase
        return half;
    endfunction

    logic        beat_q1;
    logic        beat_q2;
    logic        beat_rise;
    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [3:0]  note_idx;
    logic [3:0]  idx_next;
    logic        done_next;
    logic        note_change;
    logic        playing;
    logic        done;
    logic [16:0] half;
    logic        tone_active;
    logic [16:0] tone_cnt;
    logic        speaker;

    // Beat edge detector; both stages reset to the divider's reset level (1)
    // so releasing reset never looks like a rising beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_q1 <= 1'b1;
            beat_q2 <= 1'b1;
        end else begin
            beat_q1 <= bus.beat_in;
            beat_q2 <= beat_q1;
        end
    end

    assign beat_rise = beat_q1 & ~beat_q2;

    // Next-state logic: stop outranks a simultaneous beat; play while
    // playing is ignored; beats are only counted once already in PLAYING.
    always_comb begin
        state_next  = state;
        idx_next    = note_idx;
        done_next   = 1'b0;
        note_change = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.play && !bus.stop) begin
                    state_next = ST_PLAYING;
                    idx_next   = 4'd0;
                end
            end
            ST_PLAYING: begin
                if (bus.stop) begin
                    state_next  = ST_IDLE;
                    idx_next    = 4'd0;
                    note_change = 1'b1;
                end else if (beat_rise) begin
                    note_change = 1'b1;
                    if (note_idx == LAST_IDX) begin
                        state_next = ST_IDLE;
                        idx_next   = 4'd0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = note_idx + 4'd1;
                    end
                end
            end
        endcase
    end

    // Sequencer state, note index and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            note_idx <= 4'd0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            note_idx <= idx_next;
            playing  <= (state_next == ST_PLAYING);
            done     <= done_next;
        end
    end

    assign half        = half_period(rom_code(note_idx));
    assign tone_active = (state == ST_PLAYING) && (half != 17'd0);

    // Tone generator: count 0..half-1 then wrap and toggle; restart silent
    // on every note change, hold silent on rests and while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tone_cnt <= 17'd0;
            speaker  <= 1'b0;
        end else if (note_change || !tone_active) begin
            tone_cnt <= 17'd0;
            speaker  <= 1'b0;
        end else if (tone_cnt == half - 17'd1) begin
            tone_cnt <= 17'd0;
            speaker  <= ~speaker;
        end else begin
            tone_cnt <= tone_cnt + 17'd1;
        end
    end

    assign bus.speaker  = speaker;
    assign bus.note_idx = note_idx;
    assign bus.playing  = playing;
    assign bus.done     = done;

endmodule
